arqt_nios2_gen2_0_cpu_ocimem_arbiter: RTL
=========================================

Name: arqt_nios2_gen2_0_cpu_ocimem_arbiter

Overview:
Shares the CPU's 256x32 on-chip debug memory (ocimem, single-port, 1-cycle read latency) between two requesters:
- the CPU-side Avalon debug slave port;
- the JTAG debug path, whose sysclk-side strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and jdo arrive from the debug slave sysclk block.
The block sequences reads and writes, keeps the JTAG monitor address/data registers (MonAReg/MonDReg), and arbitrates round-robin.

Parameters:
- ADDR_W, 8, ocimem word-address width (depth = 2**ADDR_W).
- DATA_W, 32, ocimem data width; fixed at 32 for jdo field mapping.
- PROT_WORDS, 32, size of the top-of-memory protected region (used only with OCIMEM_WRPROT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- av_address  in  ADDR_W  Avalon word address.
- av_read  in  1  Avalon read request.
- av_write  in  1  Avalon write request.
- av_writedata  in  32  Avalon write data.
- av_byteenable  in  4  Avalon byte enables.
- av_waitrequest  out  1  Avalon stall.
- av_readdata  out  32  Avalon read data, valid when av_read=1 and av_waitrequest=0.
- jdo  in  38  JTAG data-out register.
- take_action_ocimem_a  in  1  strobe: load address, optional read.
- take_no_action_ocimem_a  in  1  strobe: read at MonAReg.
- take_action_ocimem_b  in  1  strobe: write at MonAReg.
- debugack  in  1  CPU is in debug mode.
- MonAReg  out  ADDR_W  JTAG monitor address.
- MonDReg  out  32  JTAG monitor data.
- jtag_busy  out  1  JTAG command pending or in flight.
- jtag_overrun  out  1  sticky: JTAG strobe dropped.
- wrprot_hit  out  1  sticky: protected write suppressed (always 0 without the macro).
- ram_addr  out  ADDR_W  ocimem address.
- ram_cs  out  1  ocimem chip select.
- ram_we  out  1  ocimem write enable.
- ram_be  out  4  ocimem byte enables.
- ram_wdata  out  32  ocimem write data.
- ram_rdata  in  32  ocimem read data, valid 1 cycle after a cs&!we access.

Behaviour:
Reset values:
- All registers and outputs 0, state IDLE, last_grant = JTAG (so Avalon wins the first tie).
- av_waitrequest = 1 while reset is asserted.

JTAG command decode:
- A JTAG strobe latches into a one-deep pending register.
- take_action_ocimem_a: MonAReg <= jdo[25:18]; if jdo[17]=1, queue a read.
- take_no_action_ocimem_a: queue a read at MonAReg.
- take_action_ocimem_b: queue a write of jdo[34:3], be=4'hF, at MonAReg.
- MonAReg increments (mod 2**ADDR_W, 8'hFF -> 8'h00) after each completed JTAG read or write.
- A strobe arriving while a command is pending or in flight is dropped and sets jtag_overrun; jtag_overrun clears only on reset.
- Simultaneous strobes: priority b > a > no_action_a; the losers are dropped and set jtag_overrun.
- jtag_busy = pending | state==JT_RD.

States: IDLE, AV_RD, JT_RD.

IDLE:
- Requesters: Avalon (av_read|av_write) and JTAG pending.
- If both request, grant the one not in last_grant; otherwise grant the sole requester. Update last_grant.
- Grant drives ram_cs=1, ram_addr/ram_we/ram_be/ram_wdata for the same cycle (combinational from IDLE and the grant).
- Avalon write granted: av_waitrequest=0 in the same cycle; stay IDLE.
- Avalon read granted: -> AV_RD, av_waitrequest=1.
- JTAG write: completes in the grant cycle, clears pending, increments MonAReg.
- JTAG read: -> JT_RD.
- If Avalon requests but is not granted: av_waitrequest=1.

AV_RD (one cycle):
- av_readdata = ram_rdata, av_waitrequest=0, ram_cs=0; -> IDLE.
- Avalon read latency is therefore 2 cycles minimum.

JT_RD (one cycle):
- MonDReg <= ram_rdata, clear pending, increment MonAReg; -> IDLE.

Other rules:
- Back-to-back: the state returns to IDLE, so the other requester is granted the next cycle. Worst-case Avalon wait is 3 cycles.
- av_read and av_write both high: treated as a write.
- Reset mid-read: state returns to IDLE, the read is discarded, and the Avalon master re-samples waitrequest=1.

Optional Feature:
OCIMEM_WRPROT_EN:
- Defined: an Avalon write to addresses >= 2**ADDR_W - PROT_WORDS while debugack=0 is acknowledged normally (waitrequest=0) but drives ram_cs=0 and sets sticky wrprot_hit. JTAG writes are never blocked.
- Undefined: no protection; wrprot_hit tied 0; debugack unused.

Decomposition:
- Package arqt_ocimem_pkg: state enum (IDLE/AV_RD/JT_RD), jdo field-position constants (addr [25:18], rd flag [17], wdata [34:3]), and the pending-command typedef {valid, is_write, addr, wdata}.
- Sub-module arqt_nios2_gen2_0_cpu_ocimem_jtag_cmd: strobe decode, one-deep pending latch, overrun flag, MonAReg increment.

Test Plan:
1. JTAG load+read: take_action_ocimem_a with jdo[25:18]=8'h10, jdo[17]=1, RAM[0x10]=32'hDEADBEEF -> MonDReg=32'hDEADBEEF 2 cycles later; MonAReg=8'h11.
2. JTAG write wrap: MonAReg=8'hFF, take_action_ocimem_b with jdo[34:3]=32'h12345678 -> RAM[0xFF]=32'h12345678, MonAReg=8'h00.
3. Collision: av_read addr 8'h04 and JTAG write pending in the same cycle, last_grant=JTAG -> Avalon granted, readdata valid at cycle 1; JTAG write at cycle 2.
4. Overrun: second take_no_action_ocimem_a while JT_RD -> jtag_overrun=1, exactly one read performed, MonAReg +1 only.
5. Avalon byte write: av_write addr 8'h20, be=4'b0010, data 32'hAABBCCDD -> ram_be=4'b0010, waitrequest=0 same cycle.
6. (OCIMEM_WRPROT_EN) av_write to 8'hE0 with debugack=0 -> no ram_cs, wrprot_hit=1; same write with debugack=1 -> RAM updated.

Source files
------------

// File: rtl/arqt_ocimem_pkg.sv
// ---------------------------------------------------------------------------
// arqt_ocimem_pkg
// Shared types and constants for the ocimem arbiter slice:
//   - ocimem_state_t : arbiter state (IDLE / AV_RD / JT_RD)
//   - grant_t        : which requester was served last (round-robin memory)
//   - JDO_*          : bit positions of the fields carried in the JTAG jdo word
//   - jtag_cmd_t     : the one-deep pending JTAG command
//   - multi_strobe() : true when more than one JTAG strobe fires at once
// ---------------------------------------------------------------------------
package arqt_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AV_RD = 2'd1,
    JT_RD = 2'd2
  } ocimem_state_t;

  typedef enum logic {
    GRANT_AV   = 1'b0,
    GRANT_JTAG = 1'b1
  } grant_t;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_HI  = 25;
  localparam int JDO_ADDR_LO  = 18;
  localparam int JDO_RD_BIT   = 17;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;

  localparam int CMD_ADDR_W = JDO_ADDR_HI - JDO_ADDR_LO + 1;
  localparam int CMD_DATA_W = JDO_WDATA_HI - JDO_WDATA_LO + 1;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } jtag_cmd_t;

  // Two or more of three strobes active in the same cycle.
  function automatic logic multi_strobe(input logic s0, input logic s1, input logic s2);
    return (s0 & s1) | (s0 & s2) | (s1 & s2);
  endfunction

endpackage

// File: rtl/arqt_nios2_gen2_0_cpu_ocimem_jtag_cmd.sv
// ---------------------------------------------------------------------------
// arqt_nios2_gen2_0_cpu_ocimem_jtag_cmd
// Decodes the sysclk-side JTAG strobes into a one-deep pending command,
// owns the monitor address register and the sticky overrun flag.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   jdo                        JTAG data-out word (address / read flag / wdata)
//   take_action_ocimem_a       load monitor address, optionally queue a read
//   take_no_action_ocimem_a    queue a read at the monitor address
//   take_action_ocimem_b       queue a full-word write at the monitor address
//   cmd_done                   arbiter finished the pending command
//   cmd                        pending command (valid while queued or in flight)
//   mon_a_reg                  monitor address register
//   overrun                    sticky: a strobe was dropped
// ---------------------------------------------------------------------------
module arqt_nios2_gen2_0_cpu_ocimem_jtag_cmd
  import arqt_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              cmd_done,
  output jtag_cmd_t         cmd,
  output logic [ADDR_W-1:0] mon_a_reg,
  output logic              overrun
);

  logic              any_strobe;
  logic [ADDR_W-1:0] jdo_addr;
  logic              unused_jdo_bits;

  assign any_strobe      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign jdo_addr        = ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
  assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_WDATA_HI+1], jdo[JDO_WDATA_LO-1:0]};

  // The pending command stays valid until the arbiter reports completion, so
  // "busy" is simply cmd.valid. A strobe that lands while busy, or that loses
  // the b > a > no_action priority, is dropped and recorded in overrun.
  // A dropped take_action_ocimem_a does not touch the monitor address either.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd       <= '0;
      mon_a_reg <= '0;
      overrun   <= 1'b0;
    end else begin
      if (any_strobe && (cmd.valid ||
          multi_strobe(take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b))) begin
        overrun <= 1'b1;
      end
      if (cmd_done) begin
        cmd.valid <= 1'b0;
        mon_a_reg <= mon_a_reg + 1'b1;
      end else if (!cmd.valid) begin
        if (take_action_ocimem_b) begin
          cmd.valid    <= 1'b1;
          cmd.is_write <= 1'b1;
          cmd.addr     <= CMD_ADDR_W'(mon_a_reg);
          cmd.wdata    <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
        end else if (take_action_ocimem_a) begin
          mon_a_reg <= jdo_addr;
          if (jdo[JDO_RD_BIT]) begin
            cmd.valid    <= 1'b1;
            cmd.is_write <= 1'b0;
            cmd.addr     <= CMD_ADDR_W'(jdo_addr);
            cmd.wdata    <= '0;
          end
        end else if (take_no_action_ocimem_a) begin
          cmd.valid    <= 1'b1;
          cmd.is_write <= 1'b0;
          cmd.addr     <= CMD_ADDR_W'(mon_a_reg);
          cmd.wdata    <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/arqt_nios2_gen2_0_cpu_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// arqt_nios2_gen2_0_cpu_ocimem_arbiter
// Shares the single-port on-chip debug memory (1-cycle read latency) between
// the Avalon debug slave and the JTAG debug path, round-robin on collisions.
// Optional build macro: OCIMEM_WRPROT_EN -- Avalon writes into the top
// PROT_WORDS words are acknowledged but suppressed unless debugack is high,
// and the sticky wrprot_hit flag records it.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   av_*                            Avalon slave (address, read, write,
//                                   writedata, byteenable, waitrequest, readdata)
//   jdo, take_*                     JTAG strobes and data word
//   debugack                        CPU in debug mode (protection bypass)
//   MonAReg, MonDReg                JTAG monitor address / data registers
//   jtag_busy, jtag_overrun         JTAG status
//   wrprot_hit                      sticky protected-write flag
//   ram_*                           memory port (addr, cs, we, be, wdata, rdata)
// ---------------------------------------------------------------------------
module arqt_nios2_gen2_0_cpu_ocimem_arbiter
  import arqt_ocimem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int PROT_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              debugack,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic              wrprot_hit,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] PROT_BASE = (ADDR_W+1)'((2**ADDR_W) - PROT_WORDS);

  ocimem_state_t state;
  grant_t        last_grant;
  jtag_cmd_t     cmd;
  logic          cmd_done;
  logic          av_req;
  logic          grant_av;
  logic          grant_jt;
  logic          in_prot;
  logic          prot_block;

  arqt_nios2_gen2_0_cpu_ocimem_jtag_cmd #(
    .ADDR_W(ADDR_W)
  ) u_jtag_cmd (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .cmd_done                (cmd_done),
    .cmd                     (cmd),
    .mon_a_reg               (MonAReg),
    .overrun                 (jtag_overrun)
  );

  assign av_req    = av_read | av_write;
  assign in_prot   = {1'b0, av_address} >= PROT_BASE;
  assign jtag_busy = cmd.valid | (state == JT_RD);
  // A JTAG write finishes in its grant cycle; a JTAG read finishes in JT_RD.
  assign cmd_done  = (grant_jt & cmd.is_write) | (state == JT_RD);

  // Grants are only issued from IDLE and never while reset is held, so a
  // master driving a request during reset cannot touch the memory. On a tie
  // the requester that was not served last wins.
  always_comb begin
    grant_av = 1'b0;
    grant_jt = 1'b0;
    if (!reset && state == IDLE) begin
      if (av_req && cmd.valid) begin
        grant_av = (last_grant == GRANT_JTAG);
        grant_jt = (last_grant == GRANT_AV);
      end else begin
        grant_av = av_req;
        grant_jt = cmd.valid;
      end
    end
  end

`ifdef OCIMEM_WRPROT_EN
  logic wrprot_q;

  assign prot_block = grant_av & av_write & in_prot & ~debugack;
  assign wrprot_hit = wrprot_q;

  // Sticky record of any suppressed protected write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrprot_q <= 1'b0;
    end else if (prot_block) begin
      wrprot_q <= 1'b1;
    end
  end
`else
  logic unused_prot;

  assign prot_block  = 1'b0;
  assign wrprot_hit  = 1'b0;
  assign unused_prot = ^{debugack, in_prot};
`endif

  // Memory port is driven straight from the grant so the access happens in
  // the grant cycle. A write with both av_read and av_write high is a write.
  // Avalon reads use all byte lanes.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_av) begin
      ram_cs    = ~prot_block;
      ram_we    = av_write & ~prot_block;
      ram_be    = av_write ? av_byteenable : 4'hF;
      ram_addr  = av_address;
      ram_wdata = av_writedata;
    end else if (grant_jt) begin
      ram_cs    = 1'b1;
      ram_we    = cmd.is_write;
      ram_be    = 4'hF;
      ram_addr  = ADDR_W'(cmd.addr);
      ram_wdata = DATA_W'(cmd.wdata);
    end
  end

  // Avalon handshake: writes are released in their grant cycle, reads one
  // cycle later in AV_RD when the memory data is on ram_rdata.
  always_comb begin
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    if (!reset) begin
      if (state == AV_RD) begin
        av_waitrequest = 1'b0;
        av_readdata    = ram_rdata;
      end else if (grant_av && av_write) begin
        av_waitrequest = 1'b0;
      end
    end
  end

  // Arbiter sequencing: both read states last one cycle and return to IDLE,
  // which gives the other requester the next grant. MonDReg captures the
  // memory data in JT_RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_JTAG;
      MonDReg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_av) begin
            last_grant <= GRANT_AV;
            if (!av_write) state <= AV_RD;
          end else if (grant_jt) begin
            last_grant <= GRANT_JTAG;
            if (!cmd.is_write) state <= JT_RD;
          end
        end
        AV_RD: state <= IDLE;
        JT_RD: begin
          MonDReg <= ram_rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
